// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment receive path:
// active-high gfedcba glyph patterns, scan FSM states and digit indices.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {IDLE, QUAL, HOLD} scan_state_t;

    localparam logic [1:0] D_UNIDAD   = 2'd0;
    localparam logic [1:0] D_DECENA   = 2'd1;
    localparam logic [1:0] D_CENTENA  = 2'd2;
    localparam logic [1:0] D_MILESIMA = 2'd3;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-high gfedcba pattern -> {legal, hex value}.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_legal,
    output logic [3:0] o_value
);

    // Table lookup; anything outside the sixteen hex glyphs is illegal
    always_comb begin
        o_legal = 1'b1;
        o_value = 4'h0;
        case (i_seg)
            SEG_0:   o_value = 4'h0;
            SEG_1:   o_value = 4'h1;
            SEG_2:   o_value = 4'h2;
            SEG_3:   o_value = 4'h3;
            SEG_4:   o_value = 4'h4;
            SEG_5:   o_value = 4'h5;
            SEG_6:   o_value = 4'h6;
            SEG_7:   o_value = 4'h7;
            SEG_8:   o_value = 4'h8;
            SEG_9:   o_value = 4'h9;
            SEG_A:   o_value = 4'hA;
            SEG_B:   o_value = 4'hB;
            SEG_C:   o_value = 4'hC;
            SEG_D:   o_value = 4'hD;
            SEG_E:   o_value = 4'hE;
            SEG_F:   o_value = 4'hF;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit 7-segment bus: qualifies each
// (digit, pattern) pair for STABLE_CYCLES edges, captures it once, flags
// illegal glyphs and pulses frame_o when all four digits have been captured.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        reloj,
    input  logic        reset,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [15:0] digits_o,
    output logic [3:0]  valid_o,
    output logic [3:0]  err_o,
    output logic        frame_o
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3:0]  w_an_n;
    logic [6:0]  w_seg_n;
    logic        w_has_idx;
    logic [1:0]  w_idx;
    logic        w_legal;
    logic [3:0]  w_value;
    logic        w_pair_same;
    logic        w_capture;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_cnt_next;
    scan_state_t w_state_next;
    logic [3:0]  w_seen_next;

    scan_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg;
    logic [3:0]  r_seen;
    logic [15:0] r_digits;
    logic [3:0]  r_valid;
    logic [3:0]  r_err;
    logic        r_frame;

    assign w_an_n  = AN_ACTIVE_LOW  ? ~an_i  : an_i;
    assign w_seg_n = SEG_ACTIVE_LOW ? ~seg_i : seg_i;

    seg7_glyph_decode u_glyph (
        .i_seg   (w_seg_n),
        .o_legal (w_legal),
        .o_value (w_value)
    );

    // One-hot enable -> digit index; blanking or overlap yields no index
    always_comb begin
        w_has_idx = 1'b1;
        w_idx     = D_UNIDAD;
        case (w_an_n)
            4'b0001: w_idx = D_UNIDAD;
            4'b0010: w_idx = D_DECENA;
            4'b0100: w_idx = D_CENTENA;
            4'b1000: w_idx = D_MILESIMA;
            default: w_has_idx = 1'b0;
        endcase
    end

    assign w_pair_same = (w_idx == r_idx) && (w_seg_n == r_seg);
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? CNT_MAX : CW'(r_cnt + CNT_ONE);

    // Next state, stability count and capture strobe; a fresh pair starts at
    // count 1 and may capture immediately when STABLE_CYCLES is 1
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        if (!w_has_idx) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else if ((r_state == QUAL) && w_pair_same) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) begin
                w_capture    = 1'b1;
                w_state_next = HOLD;
            end
        end else if ((r_state == HOLD) && w_pair_same) begin
            w_state_next = HOLD;
        end else begin
            w_cnt_next = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
                w_capture    = 1'b1;
                w_state_next = HOLD;
            end else begin
                w_state_next = QUAL;
            end
        end
    end

    assign w_seen_next = r_seen | (w_capture ? (4'b0001 << w_idx) : 4'b0000);

    // FSM state, counter and last-seen pair
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
        if (w_has_idx) begin
            r_idx <= w_idx;
            r_seg <= w_seg_n;
        end
    end

    // Capture registers, seen mask and one-cycle frame pulse
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_err    <= '0;
            r_seen   <= '0;
            r_frame  <= 1'b0;
        end else begin
            if (w_capture) begin
                if (w_legal) begin
                    r_digits[{w_idx, 2'b00} +: 4] <= w_value;
                    r_valid[w_idx]                <= 1'b1;
                    r_err[w_idx]                  <= 1'b0;
                end else begin
                    r_valid[w_idx] <= 1'b0;
                    r_err[w_idx]   <= 1'b1;
                end
            end
            if (w_seen_next == 4'hF) begin
                r_frame <= 1'b1;
                r_seen  <= 4'h0;
            end else begin
                r_frame <= 1'b0;
                r_seen  <= w_seen_next;
            end
        end
    end

    assign digits_o = r_digits;
    assign valid_o  = r_valid;
    assign err_o    = r_err;
    assign frame_o  = r_frame;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed vector table, reset-in-qualification
// sequence and randomized scanning against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int S = 4;

    logic        reloj;
    logic        reset;
    logic [3:0]  an_i;
    logic [6:0]  seg_i;
    logic [15:0] digits_o;
    logic [3:0]  valid_o;
    logic [3:0]  err_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;

    seg7_scan_decoder #(
        .STABLE_CYCLES  (S),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .reloj    (reloj),
        .reset    (reset),
        .an_i     (an_i),
        .seg_i    (seg_i),
        .digits_o (digits_o),
        .valid_o  (valid_o),
        .err_o    (err_o),
        .frame_o  (frame_o)
    );

    initial reloj = 1'b0;
    always #10 reloj = ~reloj;

    // Reference glyph set, active-high gfedcba, index = hex value
    logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: length of the current run of identical (digit, pattern) samples
    int         m_run;
    int         m_idx;
    logic [6:0] m_seg;
    logic [3:0] m_digit [4];
    bit         m_valid [4];
    bit         m_err   [4];
    bit         m_seen  [4];
    bit         m_frame;

    task automatic model_edge(input logic rst, input logic [3:0] an, input logic [6:0] seg);
        logic [3:0] a;
        logic [6:0] s;
        int idx;
        int val;
        bit all;
        if (rst) begin
            m_run = 0;
            m_frame = 0;
            for (int i = 0; i < 4; i++) begin
                m_digit[i] = 4'h0; m_valid[i] = 0; m_err[i] = 0; m_seen[i] = 0;
            end
            return;
        end
        a = ~an;
        s = ~seg;
        idx = -1;
        if ($countones(a) == 1)
            for (int i = 0; i < 4; i++) if (a[i]) idx = i;
        if (idx < 0) m_run = 0;
        else if (m_run > 0 && idx == m_idx && s == m_seg) m_run = (m_run > S) ? m_run : m_run + 1;
        else m_run = 1;
        m_idx = idx;
        m_seg = s;
        m_frame = 0;
        if (idx >= 0 && m_run == S) begin
            val = -1;
            for (int v = 0; v < 16; v++) if (gly[v] == s) val = v;
            if (val >= 0) begin
                m_digit[idx] = 4'(val); m_valid[idx] = 1; m_err[idx] = 0;
            end else begin
                m_valid[idx] = 0; m_err[idx] = 1;
            end
            m_seen[idx] = 1;
            all = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
            if (all) begin
                m_frame = 1;
                for (int i = 0; i < 4; i++) m_seen[i] = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [15:0] d;
        logic [3:0]  v;
        logic [3:0]  e;
        for (int i = 0; i < 4; i++) begin
            d[i*4 +: 4] = m_digit[i];
            v[i] = m_valid[i];
            e[i] = m_err[i];
        end
        check("model_digits", 32'(digits_o), 32'(d));
        check("model_valid", 32'(valid_o), 32'(v));
        check("model_err", 32'(err_o), 32'(e));
        check("model_frame", 32'(frame_o), 32'(m_frame));
    endtask

    // Drive one edge worth of inputs, advance the model, sample 1 ns after the edge
    task automatic tick(input logic rst, input logic [3:0] an, input logic [6:0] seg);
        reset = rst;
        an_i  = an;
        seg_i = seg;
        @(posedge reloj);
        model_edge(rst, an, seg);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          edges;
        logic [15:0] digits;
        logic [3:0]  valid;
        logic [3:0]  err;
        int          frames;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] an, input logic [6:0] seg,
                                input int edges, input logic [15:0] digits,
                                input logic [3:0] valid, input logic [3:0] err, input int frames);
        vec_t t;
        t.rst = rst; t.an = an; t.seg = seg; t.edges = edges;
        t.digits = digits; t.valid = valid; t.err = err; t.frames = frames;
        return t;
    endfunction

    vec_t vecs [$];

    initial begin
        int fr;
        logic [3:0] an;
        logic [6:0] pat;
        int len;
        logic r;

        reset = 1'b1;
        an_i  = 4'hF;
        seg_i = 7'h7F;

        // Reset with random bus activity
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 4'($urandom), 7'($urandom));
            check("rst_digits", 32'(digits_o), 32'h0);
            check("rst_valid", 32'(valid_o), 32'h0);
            check("rst_err", 32'(err_o), 32'h0);
            check("rst_frame", 32'(frame_o), 32'h0);
        end

        // rst, an, seg, edges, digits, valid, err, frames
        vecs.push_back(mk(0, 4'b1110, 7'h79, 3,  16'h0000, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1110, 7'h79, 1,  16'h0001, 4'h1, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1110, 7'h79, 20, 16'h0001, 4'h1, 4'h0, 0));
        vecs.push_back(mk(1, 4'hF,    7'h7F, 1,  16'h0000, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'h0000, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 4'b0111, 7'h08, 6,  16'hA000, 4'h8, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'hA000, 4'h8, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1011, 7'h12, 6,  16'hA500, 4'hC, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'hA500, 4'hC, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1101, 7'h30, 6,  16'hA530, 4'hE, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'hA530, 4'hE, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1110, 7'h40, 6,  16'hA530, 4'hF, 4'h0, 1));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'hA530, 4'hF, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1101, 7'h00, 3,  16'hA530, 4'hF, 4'h0, 0));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'hA530, 4'hF, 4'h0, 0));
        vecs.push_back(mk(0, 4'b1011, 7'h7E, 4,  16'hA530, 4'hB, 4'h4, 0));
        vecs.push_back(mk(0, 4'hF,    7'h7F, 2,  16'hA530, 4'hB, 4'h4, 0));
        vecs.push_back(mk(0, 4'b1100, 7'h00, 10, 16'hA530, 4'hB, 4'h4, 0));

        foreach (vecs[i]) begin
            fr = 0;
            for (int e = 0; e < vecs[i].edges; e++) begin
                tick(vecs[i].rst, vecs[i].an, vecs[i].seg);
                if (frame_o) fr++;
            end
            check($sformatf("vec%0d_digits", i), 32'(digits_o), 32'(vecs[i].digits));
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].valid));
            check($sformatf("vec%0d_err", i), 32'(err_o), 32'(vecs[i].err));
            check($sformatf("vec%0d_frames", i), 32'(fr), 32'(vecs[i].frames));
        end

        // Reset on the 3rd edge of a qualification run, then 4 fresh edges to capture '4'
        tick(1'b0, 4'b1110, 7'h19);
        tick(1'b0, 4'b1110, 7'h19);
        tick(1'b1, 4'b1110, 7'h19);
        check("qrst_digits", 32'(digits_o), 32'h0);
        check("qrst_valid", 32'(valid_o), 32'h0);
        for (int e = 0; e < 3; e++) tick(1'b0, 4'b1110, 7'h19);
        check("qrst_early_digits", 32'(digits_o), 32'h0);
        check("qrst_early_valid", 32'(valid_o), 32'h0);
        tick(1'b0, 4'b1110, 7'h19);
        check("qrst_cap_digits", 32'(digits_o), 32'h0004);
        check("qrst_cap_valid", 32'(valid_o), 32'h1);

        // Randomized scanning with blanking, overlaps, illegal glyphs and sporadic reset
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 9))
                0:       an = 4'hF;
                1:       an = 4'($urandom);
                default: an = ~(4'b0001 << $urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 4) == 0) pat = 7'($urandom);
            else                           pat = gly[$urandom_range(0, 15)];
            len = $urandom_range(1, 7);
            for (int e = 0; e < len; e++) tick(r && (e == 0), an, ~pat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
